// File: rtl/fetch_queue.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | fetch_queue : in-order instruction fetch front end with a PC/inst FIFO    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int C_AW = $clog2(DEPTH);
  localparam int C_CW = C_AW + 1;
  // Drops can accumulate over back-to-back redirects, so give them headroom.
  localparam int C_DW = C_CW + 4;

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     resp_pc_q,  resp_pc_d;
  logic [C_CW-1:0] live_q,     live_d;
  logic [C_DW-1:0] drop_q,     drop_d;
  logic [C_CW-1:0] count_q,    count_d;
  logic [C_AW-1:0] head_q,     head_d;
  logic [C_AW-1:0] tail_q,     tail_d;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];

  logic [C_CW:0] w_inflight;
  logic          w_accept;
  logic          w_push;
  logic          w_drop_rsp;
  logic          w_pop;
  logic          w_unused_ok;

  assign w_unused_ok = &{1'b0, redirect_pc[1:0]};

  // Credit rule: every accepted-but-kept request owns a queue slot.
  assign w_inflight = {1'b0, count_q} + {1'b0, live_q};
  assign imem_req   = !rst && !redirect_valid && (w_inflight < (C_CW+1)'(DEPTH));
  assign imem_addr  = fetch_pc_q;

  assign w_accept   = imem_req && imem_gnt;
  assign w_drop_rsp = imem_rvalid && (drop_q != '0);
  assign w_push     = imem_rvalid && (drop_q == '0) && (live_q != '0);

  assign out_valid   = (count_q != '0);
  assign w_pop       = out_valid && out_ready;
  assign out_pc      = out_valid ? pc_mem[head_q]   : 32'h0;
  assign out_inst    = out_valid ? inst_mem[head_q] : 32'h0;
  assign queue_count = count_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    live_d     = live_q;
    drop_d     = drop_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      resp_pc_d  = {redirect_pc[31:2], 2'b00};
      live_d     = '0;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      drop_d     = drop_q + C_DW'(live_q)
                 - C_DW'(imem_rvalid && ((drop_q != '0) || (live_q != '0)));
    end else begin
      if (w_accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (w_push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        tail_d    = tail_q + C_AW'(1);
      end
      if (w_drop_rsp) drop_d = drop_q - C_DW'(1);
      if (w_pop)      head_d = head_q + C_AW'(1);
      live_d  = live_q + C_CW'(w_accept) - C_CW'(w_push);
      count_d = count_q + C_CW'(w_push) - C_CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      live_q     <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      live_q     <= live_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !redirect_valid && w_push) begin
      pc_mem[tail_q]   <= resp_pc_q;
      inst_mem[tail_q] <= imem_rdata;
    end
  end

  // A response with nothing outstanding means the memory broke protocol.
  always_ff @(posedge clk) begin
    if (!rst && imem_rvalid) begin
      assert ((live_q != '0) || (drop_q != '0))
        else $error("fetch_queue: imem_rvalid with no outstanding request");
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_fetch_queue : scoreboard bench with an in-order latency memory model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  queue_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 1;

  typedef struct packed {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       pend[$];
  logic [63:0] exp_q[$];

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .queue_count    (queue_count)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_run(input logic [31:0] start, input int n);
    logic [31:0] pc;
    pc = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({pc, pc + 32'h100});
      pc = pc + 32'd4;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    redirect_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    out_ready = 1'b0;
  endtask

  // Memory request capture: an accept seen here completes at the next edge.
  initial forever begin
    @(negedge clk);
    if (rst) pend.delete();
    else if (imem_req && imem_gnt) pend.push_back('{addr: imem_addr, due: cyc + lat});
  end

  // Memory response driver: one in-order response per cycle once due.
  initial forever begin
    @(posedge clk);
    #2;
    if (rst) begin
      pend.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end else if (pend.size() != 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend[0].addr + 32'h100;
      void'(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  end

  // Scoreboard monitor: every handshake must match the next expected entry.
  initial forever begin
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop_pc", out_pc, 32'hDEAD_BEEF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", out_pc, e[63:32]);
        chk("sb_inst", out_inst, e[31:0]);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    imem_gnt       = 1'b1;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_inst", out_inst, 32'h0);
    chk("rst_count", 32'(queue_count), 32'd0);

    // Streaming from reset with 1-cycle memory
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    expect_run(32'h0, 16);
    @(negedge clk);
    chk("p1_req0", 32'(imem_req), 32'd1);
    chk("p1_addr0", imem_addr, 32'h0);
    chk("p1_valid_c0", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("p1_valid_c1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("p1_valid_c2", 32'(out_valid), 32'd1);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk("p1_valid_stream", 32'(out_valid), 32'd1);
    end
    drain("p1");

    // Fill with decode stalled, then release
    do_reset();
    expect_run(32'h0, 12);
    repeat (8) @(negedge clk);
    chk("p2_count_full", 32'(queue_count), 32'd4);
    chk("p2_req_full", 32'(imem_req), 32'd0);
    chk("p2_addr_full", imem_addr, 32'h10);
    chk("p2_head_pc", out_pc, 32'h0);
    chk("p2_head_inst", out_inst, 32'h100);
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("p2_valid_release", 32'(out_valid), 32'd1);
    end
    drain("p2");

    // Redirect with two stale requests outstanding, 3-cycle memory
    lat = 3;
    do_reset();
    out_ready = 1'b1;
    expect_run(32'h200, 8);
    repeat (2) @(posedge clk);
    #1 redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    @(negedge clk);
    chk("p3_req_redirect", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    @(negedge clk);
    chk("p3_req_after", 32'(imem_req), 32'd1);
    chk("p3_addr_after", imem_addr, 32'h200);
    chk("p3_count_after", 32'(queue_count), 32'd0);
    drain("p3");

    // Redirect coinciding with a response and a pop
    lat = 1;
    do_reset();
    out_ready = 1'b1;
    expect_run(32'h0, 6);
    expect_run(32'h400, 4);
    repeat (7) @(posedge clk);
    #1 redirect_valid = 1'b1;
    redirect_pc = 32'h400;
    @(negedge clk);
    chk("p4_rvalid_in_redirect", 32'(imem_rvalid), 32'd1);
    chk("p4_pop_in_redirect", 32'(out_valid), 32'd1);
    chk("p4_req_redirect", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    @(negedge clk);
    chk("p4_count_flushed", 32'(queue_count), 32'd0);
    chk("p4_valid_flushed", 32'(out_valid), 32'd0);
    chk("p4_addr_target", imem_addr, 32'h400);
    chk("p4_req_target", 32'(imem_req), 32'd1);
    @(negedge clk);
    chk("p4_valid_t2", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("p4_valid_t3", 32'(out_valid), 32'd1);
    drain("p4");

    // Redirect near the top of the address space: PC wraps to zero
    @(posedge clk);
    #1 redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    expect_run(32'hFFFF_FFF8, 4);
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    out_ready = 1'b1;
    drain("p5");

    // Reset mid-stream with a full queue
    repeat (8) @(negedge clk);
    chk("p6_count_full", 32'(queue_count), 32'd4);
    chk("p6_req_full", 32'(imem_req), 32'd0);
    do_reset();
    @(negedge clk);
    chk("p6_valid_rst", 32'(out_valid), 32'd0);
    chk("p6_count_rst", 32'(queue_count), 32'd0);
    chk("p6_addr_rst", imem_addr, 32'h0);
    chk("p6_req_rst", 32'(imem_req), 32'd1);
    #2 out_ready = 1'b1;
    expect_run(32'h0, 4);
    drain("p6");

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
